// File: rtl/spi_pkg.sv
// Shared types and constants for the daisy-chain SPI sequencer.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE,
        ST_ERR
    } state_e;

    // Mode 0: s_clk rests low between transfers
    localparam logic SCLK_IDLE = 1'b0;

    // Counter width that stays legal when the count range collapses to one value
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_chain_ctrl_if.sv
// Request/response handshake between the bus front-end and the SPI sequencer.
interface spi_chain_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [DATA_W-1:0]  req_data;
    logic [NUM_SLV-1:0] req_sel;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_err;
    logic               busy;

    modport master (
        output req_valid, req_data, req_sel,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_data, req_sel,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/spi_clk_gen.sv
// CLK_DIV half-period divider; toggles s_clk only while toggle_en_i is set.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic toggle_en_i,
    output logic tick_o,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic s_clk_o
);
    localparam int CW = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_clk_q, s_clk_d;

    assign tick_o      = en_i && (cnt_q == LAST);
    assign rise_tick_o = toggle_en_i && tick_o && (s_clk_q == SCLK_IDLE);
    assign fall_tick_o = toggle_en_i && tick_o && (s_clk_q != SCLK_IDLE);
    assign s_clk_o     = s_clk_q;

    // Counter restarts from 0 whenever the FSM drops enable, so every
    // timed state gets a full CLK_DIV window.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || tick_o) cnt_d = '0;
        s_clk_d = s_clk_q;
        if (rise_tick_o)                     s_clk_d = ~SCLK_IDLE;
        else if (fall_tick_o || !toggle_en_i) s_clk_d = SCLK_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            s_clk_q <= SCLK_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            s_clk_q <= s_clk_d;
        end
    end
endmodule

// File: rtl/spi_chain_ctrl.sv
// Daisy-chain SPI transaction sequencer: one parallel word in, mode-0 serial
// transfer on s_clk/mosi/miso, captured word back on a response pulse.
module spi_chain_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 4,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    spi_chain_ctrl_if.slave    bus,
    output logic               s_clk,
    output logic [NUM_SLV-1:0] m_chip_sel,
    output logic               mosi,
    input  logic               miso
);
    localparam int BW = $clog2(DATA_W + 1);

    state_e             state_q, state_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic               accept, div_en, tog_en;
    logic               tick, rise_tick, fall_tick;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk         (clk),
        .rst         (reset),
        .en_i        (div_en),
        .toggle_en_i (tog_en),
        .tick_o      (tick),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick),
        .s_clk_o     (s_clk)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (|bus.req_sel) ? ST_SETUP : ST_ERR;
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (fall_tick && bit_q == BW'(1)) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_en     = 1'b0;
        tog_en     = 1'b0;
        m_chip_sel = '0;
        case (state_q)
            ST_SETUP, ST_HOLD: begin
                div_en     = 1'b1;
                m_chip_sel = sel_q;
            end
            ST_SHIFT: begin
                div_en     = 1'b1;
                tog_en     = 1'b1;
                m_chip_sel = sel_q;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign bus.rsp_err   = (state_q == ST_ERR);
    assign bus.rsp_data  = rsp_data_q;
    assign mosi          = tx_q[DATA_W-1];

    // A rejected request must not disturb the pins, so only legal selects load.
    // The last fall leaves tx alone so mosi keeps the LSB through HOLD.
    always_comb begin
        tx_d       = tx_q;
        rx_d       = rx_q;
        sel_d      = sel_q;
        bit_d      = bit_q;
        rsp_data_d = rsp_data_q;
        if (accept && (|bus.req_sel)) begin
            tx_d  = bus.req_data;
            sel_d = bus.req_sel;
            rx_d  = '0;
            bit_d = BW'(DATA_W);
        end
        if (rise_tick) rx_d = {rx_q[DATA_W-2:0], miso};
        if (fall_tick) begin
            if (bit_q != '0)     bit_d = bit_q - 1'b1;
            if (bit_q > BW'(1))  tx_d  = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (state_q == ST_HOLD && tick) rsp_data_d = rx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q       <= '0;
            rx_q       <= '0;
            sel_q      <= '0;
            bit_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sel_q      <= sel_d;
            bit_q      <= bit_d;
            rsp_data_q <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_spi_chain_ctrl.sv
// Bench for spi_chain_ctrl: vector table + scoreboard on the default build,
// plus a CLK_DIV=1 / DATA_W=16 instance for the fast-divider corner.
module tb_spi_chain_ctrl;
    localparam int DW   = 8;
    localparam int NS   = 4;
    localparam int CD   = 4;
    localparam int LAT  = 73;
    localparam int DW2  = 16;
    localparam int LAT2 = 35;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            pulses;
        logic [DW-1:0] mosi_w;
        logic [NS-1:0] sel;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [NS-1:0] sel;
        bit            loop;
        logic [DW-1:0] pat;
        logic [DW-1:0] exp_d;
        bit            exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_chain_ctrl_if #(.DATA_W(DW), .NUM_SLV(NS)) bus ();
    spi_chain_ctrl_if #(.DATA_W(DW2), .NUM_SLV(NS)) bus2 ();

    logic          s_clk, mosi, miso, s_clk2, mosi2;
    logic [NS-1:0] sel, sel2;
    bit            loop_en = 1'b1;
    logic [DW-1:0] pat = '0;
    int            pidx = DW - 1;

    assign miso = loop_en ? mosi : pat[pidx];

    spi_chain_ctrl #(.DATA_W(DW), .NUM_SLV(NS), .CLK_DIV(CD)) dut (
        .clk(clk), .reset(rst), .bus(bus), .s_clk(s_clk),
        .m_chip_sel(sel), .mosi(mosi), .miso(miso));

    spi_chain_ctrl #(.DATA_W(DW2), .NUM_SLV(NS), .CLK_DIV(1)) dut2 (
        .clk(clk), .reset(rst), .bus(bus2), .s_clk(s_clk2),
        .m_chip_sel(sel2), .mosi(mosi2), .miso(mosi2));

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   chk_b2b = 1'b0;
    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Pattern source advances just after each s_clk rise, once the DUT has sampled
    initial forever begin
        @(posedge s_clk);
        #1;
        if (pidx > 0) pidx--;
    end

    // Response monitor / scoreboard consumer
    initial begin
        exp_t          e;
        int            cyc = 0, lat = 0, pulses = 0, hi_len = 0, last_rsp = 0;
        logic          prev = 1'b0;
        logic [DW-1:0] mcap = '0;
        logic [NS-1:0] sel_or = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev   = 1'b0;
                hi_len = 0;
            end else begin
                lat++;
                sel_or |= sel;
                if (s_clk && !prev) begin
                    pulses++;
                    mcap = {mcap[DW-2:0], mosi};
                end
                if (s_clk) hi_len++;
                else if (prev) begin
                    chk("s_clk high width", hi_len, CD);
                    hi_len = 0;
                end
                prev = s_clk;
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected rsp_valid at cycle %0d", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_data", bus.rsp_data, e.data);
                        chk("rsp_err", bus.rsp_err, e.err);
                        chk("latency", lat, e.lat);
                        chk("s_clk pulses", pulses, e.pulses);
                        chk("select seen", sel_or, e.sel);
                        if (!e.err) chk("mosi sequence", mcap, e.mosi_w);
                    end
                    last_rsp = cyc;
                end
                if (bus.req_valid && bus.req_ready) begin
                    if (chk_b2b) begin
                        chk("b2b accept gap", cyc - last_rsp, 1);
                        chk_b2b = 1'b0;
                    end
                    lat    = 0;
                    pulses = 0;
                    mcap   = '0;
                    sel_or = sel;
                end
            end
        end
    end

    // Caller enters just after a rising edge; returns just after the accept edge
    task automatic send(input logic [DW-1:0] d, input logic [NS-1:0] s, input exp_t e, input bit keep);
        int n;
        n = 0;
        bus.req_data  = d;
        bus.req_sel   = s;
        bus.req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 300);
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept timeout: req_ready=%0b after %0d cycles", bus.req_ready, n);
        end else sb.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || bus.busy) begin
            errors++;
            $display("FAIL idle timeout: pending=%0d busy=%0b, expected 0/0", sb.size(), bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input logic err, input logic [DW-1:0] tx,
                                input logic [NS-1:0] s);
        exp_t e;
        e.data   = d;
        e.err    = err;
        e.lat    = err ? 1 : LAT;
        e.pulses = err ? 0 : DW;
        e.mosi_w = tx;
        e.sel    = err ? '0 : s;
        return e;
    endfunction

    initial begin
        int   n, hi, pc;
        logic pv;
        vt[0] = '{8'hA5, 4'b0001, 1'b1, 8'h00, 8'hA5, 1'b0};
        vt[1] = '{8'h81, 4'b0010, 1'b0, 8'h3C, 8'h3C, 1'b0};
        vt[2] = '{8'h5A, 4'b0000, 1'b1, 8'h00, 8'h3C, 1'b1};
        vt[3] = '{8'hFF, 4'b1111, 1'b1, 8'h00, 8'hFF, 1'b0};
        vt[4] = '{8'h00, 4'b0100, 1'b0, 8'h01, 8'h01, 1'b0};
        vt[5] = '{8'h80, 4'b1000, 1'b1, 8'h00, 8'h80, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_data   = '0;
        bus.req_sel    = '0;
        bus2.req_valid = 1'b0;
        bus2.req_data  = '0;
        bus2.req_sel   = '0;

        #12;
        chk("reset req_ready", bus.req_ready, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset rsp_err", bus.rsp_err, 0);
        chk("reset rsp_data", bus.rsp_data, 0);
        chk("reset s_clk", s_clk, 0);
        chk("reset m_chip_sel", sel, 0);
        chk("reset mosi", mosi, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            loop_en = vt[i].loop;
            pat     = vt[i].pat;
            pidx    = DW - 1;
            send(vt[i].data, vt[i].sel, mk(vt[i].exp_d, vt[i].exp_err, vt[i].data, vt[i].sel), 1'b0);
            wait_idle();
        end

        // Back-to-back with req_valid held across both transfers
        loop_en = 1'b1;
        send(8'hC3, 4'b1000, mk(8'hC3, 1'b0, 8'hC3, 4'b1000), 1'b1);
        chk_b2b = 1'b1;
        send(8'h3E, 4'b0100, mk(8'h3E, 1'b0, 8'h3E, 4'b0100), 1'b0);
        wait_idle();
        chk("b2b gap checked", chk_b2b, 0);

        // Reset while s_clk is high mid-transfer
        send(8'hA5, 4'b0010, mk(8'hA5, 1'b0, 8'hA5, 4'b0010), 1'b0);
        n = 0;
        while (!s_clk && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached shift", s_clk, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid reset s_clk", s_clk, 0);
        chk("mid reset m_chip_sel", sel, 0);
        chk("mid reset busy", bus.busy, 0);
        chk("mid reset req_ready", bus.req_ready, 1);
        chk("mid reset rsp_valid", bus.rsp_valid, 0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Fast divider, wide word, loopback on the second instance
        bus2.req_data  = 16'hBEEF;
        bus2.req_sel   = 4'b0001;
        bus2.req_valid = 1'b1;
        @(negedge clk);
        chk("dut2 ready", bus2.req_ready, 1);
        @(posedge clk);
        #1 bus2.req_valid = 1'b0;
        n  = 0;
        hi = 0;
        pc = 0;
        pv = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (s_clk2) hi++;
            if (s_clk2 && !pv) pc++;
            pv = s_clk2;
        end while (!bus2.rsp_valid && n < 200);
        chk("dut2 latency", n, LAT2);
        chk("dut2 rsp_data", bus2.rsp_data, 16'hBEEF);
        chk("dut2 rsp_err", bus2.rsp_err, 0);
        chk("dut2 s_clk pulses", pc, DW2);
        chk("dut2 s_clk high cycles", hi, DW2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
